// File: rtl/sync_sram_2p_pkg.sv
// Shared defaults and clear-engine state encoding for sync_sram_2p.
package sync_sram_2p_pkg;

   localparam int unsigned DEF_ADDRESS_BIT = 4;
   localparam int unsigned DEF_DATA_BIT    = 8;
   localparam int unsigned DEF_LANE_BIT    = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

endpackage

// File: rtl/sram_core.sv
// Storage array with lane-masked synchronous write and combinational read.
// Contents are never reset.
module sram_core
   import sync_sram_2p_pkg::*;
#(
   parameter int unsigned ADDRESS_BIT = DEF_ADDRESS_BIT,
   parameter int unsigned DATA_BIT    = DEF_DATA_BIT,
   parameter int unsigned LANE_BIT    = DEF_LANE_BIT
) (
   input  logic                              ck,
   input  logic                              we,
   input  logic [ADDRESS_BIT-1:0]            waddr,
   input  logic [DATA_BIT-1:0]               wdata,
   input  logic [DATA_BIT/LANE_BIT-1:0]      wbe,
   input  logic [ADDRESS_BIT-1:0]            raddr,
   output logic [DATA_BIT-1:0]               rdata
);

   localparam int unsigned NLANE = DATA_BIT / LANE_BIT;
   localparam int unsigned DEPTH = 1 << ADDRESS_BIT;

   logic [DATA_BIT-1:0] mem_q [DEPTH];

   // Update only the enabled lanes of the addressed word.
   always_ff @(posedge ck) begin
      if (we) begin
         for (int unsigned i = 0; i < NLANE; i++) begin
            if (wbe[i]) begin
               mem_q[waddr][i*LANE_BIT +: LANE_BIT] <= wdata[i*LANE_BIT +: LANE_BIT];
            end
         end
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_sram_2p.sv
// Two-port synchronous SRAM: one write and one read port, write-first
// bypass, optional output register and a whole-array clear engine.
module sync_sram_2p
   import sync_sram_2p_pkg::*;
#(
   parameter int unsigned ADDRESS_BIT = DEF_ADDRESS_BIT,
   parameter int unsigned DATA_BIT    = DEF_DATA_BIT,
   parameter int unsigned LANE_BIT    = DEF_LANE_BIT,
   parameter bit          OUT_REG     = 1'b0
) (
   input  logic                              ck,
   input  logic                              rst_n,
   input  logic                              cs,
   input  logic                              we,
   input  logic [ADDRESS_BIT-1:0]            waddr,
   input  logic [DATA_BIT-1:0]               wdata,
   input  logic [DATA_BIT/LANE_BIT-1:0]      wbe,
   input  logic                              re,
   input  logic [ADDRESS_BIT-1:0]            raddr,
   output logic [DATA_BIT-1:0]               rdata,
   output logic                              rvalid,
   input  logic                              clr,
   output logic                              busy
);

   localparam int unsigned NLANE = DATA_BIT / LANE_BIT;

   clr_state_e               state_q, state_d;
   logic [ADDRESS_BIT-1:0]   cnt_q, cnt_d;

   logic                     wr_acc, rd_acc;
   logic                     core_we;
   logic [ADDRESS_BIT-1:0]   core_waddr;
   logic [DATA_BIT-1:0]      core_wdata, core_rdata, rd_word;
   logic [NLANE-1:0]         core_wbe;

   logic [DATA_BIT-1:0]      pipe_q, rdata_q;
   logic                     pvld_q, rvalid_q;

   assign busy   = (state_q == ST_CLEAR);
   // A clear request in the same cycle takes priority over a write.
   assign wr_acc = cs & we & ~busy & ~clr;
   assign rd_acc = cs & re & ~busy;

   // Clear engine state and counter registers.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Clear engine next state: one word per cycle, stop after the last address.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clr) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == '1) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Array write port: user write when idle, zero-fill word while clearing.
   always_comb begin
      core_we    = wr_acc;
      core_waddr = waddr;
      core_wdata = wdata;
      core_wbe   = wbe;
      if (busy) begin
         core_we    = 1'b1;
         core_waddr = cnt_q;
         core_wdata = '0;
         core_wbe   = '1;
      end
   end

   sram_core #(
      .ADDRESS_BIT (ADDRESS_BIT),
      .DATA_BIT    (DATA_BIT),
      .LANE_BIT    (LANE_BIT)
   ) u_core (
      .ck    (ck),
      .we    (core_we),
      .waddr (core_waddr),
      .wdata (core_wdata),
      .wbe   (core_wbe),
      .raddr (raddr),
      .rdata (core_rdata)
   );

   // Write-first bypass: merge enabled lanes of a same-address write.
   always_comb begin
      rd_word = core_rdata;
      if (wr_acc && (waddr == raddr)) begin
         for (int unsigned i = 0; i < NLANE; i++) begin
            if (wbe[i]) begin
               rd_word[i*LANE_BIT +: LANE_BIT] = wdata[i*LANE_BIT +: LANE_BIT];
            end
         end
      end
   end

   // Read output path; the pipeline stage is not gated by busy so an
   // in-flight read still completes with pre-clear data.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         pipe_q   <= '0;
         pvld_q   <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else if (OUT_REG) begin
         pvld_q   <= rd_acc;
         if (rd_acc) pipe_q <= rd_word;
         rvalid_q <= pvld_q;
         if (pvld_q) rdata_q <= pipe_q;
      end else begin
         rvalid_q <= rd_acc;
         if (rd_acc) rdata_q <= rd_word;
      end
   end

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;

endmodule
